regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth NREG = 2**ADDR_W.
REQ-003 SHALL have parameter N_RD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: ra  input  N_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port: rd  output  N_RD*DATA_W  packed read data, packed the same way as ra.
REQ-009 SHALL have port: rd_busy  output  N_RD  per-port pending flag for the addressed register.
REQ-010 SHALL have port: we  input  1  write enable, active high.
REQ-011 SHALL have port: wa  input  ADDR_W  write address.
REQ-012 SHALL have port: wd  input  DATA_W  write data.
REQ-013 SHALL have port: set_en  input  1  marks register set_addr pending (scoreboard issue).
REQ-014 SHALL have port: set_addr  input  ADDR_W  scoreboard address.
REQ-015 SHALL have port: clr_req  input  1  one-cycle request to start a soft clear.
REQ-016 SHALL have port: clr_busy  output  1  high while the soft clear is in progress.
REQ-017 SHALL have port: clr_done  output  1  one-cycle pulse when the soft clear finishes.

Function
REQ-018 Reads SHALL be combinational with zero latency, and all N_RD ports SHALL be independent.
REQ-019 Register 0 SHALL always read 0 with rd_busy 0; writes and set_en targeting address 0 SHALL be ignored.
REQ-020 Writes SHALL commit on the rising clk edge when we=1, wa!=0 and state=IDLE.
REQ-021 Bypass: when we=1, wa==ra[i], wa!=0 and state=IDLE, rd[i] SHALL return wd in the same cycle.
REQ-022 Scoreboard: pending[a] SHALL be set at the edge where set_en=1 and set_addr=a, and cleared at the edge where an accepted write has wa=a.
REQ-023 If set_en and we target the same address in the same cycle, set SHALL win: data commits and pending ends at 1.
REQ-024 rd_busy[i] SHALL equal pending[ra[i]] with write bypass applied, i.e. 0 when a same-cycle accepted write targets ra[i], unless REQ-023 applies.
REQ-025 FSM states SHALL be IDLE and CLEAR.
REQ-026 Transition IDLE->CLEAR SHALL occur on clr_req=1; at that edge the pointer loads 1 and all pending bits clear.
REQ-027 In CLEAR, one register (pointer) SHALL be zeroed per cycle, and the pointer SHALL increment.
REQ-028 Transition CLEAR->IDLE SHALL occur after register NREG-1 is zeroed; clr_done SHALL pulse for one cycle at that point (registered, with clr_busy already low).
REQ-029 clr_busy SHALL be 1 exactly in CLEAR; the clear takes NREG-1 cycles (31 at the defaults).
REQ-030 In CLEAR, we, set_en and clr_req SHALL be ignored; reads SHALL return current storage with no bypass, so already-cleared entries read 0.
REQ-031 The pointer SHALL be ADDR_W bits wide and SHALL terminate on reaching all-ones, without wrapping into register 0.

Reset
REQ-032 rst_n=0 SHALL asynchronously force all registers to 0, pending to 0, state to IDLE, pointer to 0, clr_busy to 0 and clr_done to 0.
REQ-033 Reset asserted mid-CLEAR SHALL abort the clear; no clr_done SHALL be emitted.
REQ-034 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-035 A shared package rf_pkg SHALL hold the FSM state enum (RF_IDLE, RF_CLEAR) and the default DATA_W/ADDR_W constants.
REQ-036 The per-port read mux plus bypass SHALL be one sub-module, rf_rdport, instantiated N_RD times via generate.
REQ-037 The storage array, scoreboard and FSM SHALL reside in regfile_mp.

Verification
REQ-038 Reset then read all ports at addresses 0..31 -> rd=0 and rd_busy=0 everywhere.
REQ-039 Write 0xDEADBEEF to r5 while ra0=5 in the same cycle -> rd0=0xDEADBEEF that cycle (bypass) and on the next cycle (stored).
REQ-040 Write 0x1234 to r0, then read ra1=0 -> rd1=0 and rd_busy1=0.
REQ-041 set_en r7, then next cycle read ra0=7 -> rd_busy0=1; later we r7=0x55 -> rd_busy0=0 in the same cycle; set_en and we to r7 in the same cycle -> pending remains 1.
REQ-042 Fill r1..r31, pulse clr_req, drive we during CLEAR -> clr_busy high for 31 cycles, one clr_done pulse, all registers 0, ignored writes absent.
REQ-043 Assert rst_n=0 at clear cycle 10 -> immediate IDLE, no clr_done, all registers read 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

endpackage

// File: rtl/rf_rdport.sv
// One combinational read port: register mux, r0 forced to zero, same-cycle write bypass.
module rf_rdport
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   localparam int unsigned NREG  = 2 ** ADDR_W
) (
   input  logic [NREG-1:0][DATA_W-1:0] regs,
   input  logic [NREG-1:0]             pending,
   input  logic [ADDR_W-1:0]           ra,
   input  logic                        byp_en,
   input  logic                        byp_busy_clr,
   input  logic [ADDR_W-1:0]           wa,
   input  logic [DATA_W-1:0]           wd,
   output logic [DATA_W-1:0]           rd,
   output logic                        busy
);

   logic hit;

   assign hit = (wa == ra);

   always_comb begin
      rd   = '0;
      busy = 1'b0;
      if (ra != '0) begin
         rd   = (byp_en && hit) ? wd : regs[ra];
         // A same-cycle set to the written address keeps the current pending view.
         busy = pending[ra] && !(byp_busy_clr && hit);
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a pending-write scoreboard and a sequential soft clear.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned N_RD   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_RD*ADDR_W-1:0]   ra,
   output logic [N_RD*DATA_W-1:0]   rd,
   output logic [N_RD-1:0]          rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done
);

   localparam int unsigned       NREG     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   rf_state_e                   state_q, state_d;
   logic [ADDR_W-1:0]           ptr_q, ptr_d;
   logic                        clr_done_q, clr_done_d;
   logic [NREG-1:0][DATA_W-1:0] regs_q;
   logic [NREG-1:0]             pending_q;

   logic idle, wr_ok, set_ok, set_wr_same;

   assign idle        = (state_q == RF_IDLE);
   assign wr_ok       = idle && we && (wa != '0);
   assign set_ok      = idle && set_en && (set_addr != '0);
   assign set_wr_same = set_ok && (set_addr == wa);

   assign clr_busy = (state_q == RF_CLEAR);
   assign clr_done = clr_done_q;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clr_done_d = 1'b0;
      unique case (state_q)
         RF_IDLE: begin
            if (clr_req) begin
               state_d = RF_CLEAR;
               ptr_d   = ADDR_W'(1);
            end
         end
         RF_CLEAR: begin
            // Stop at all-ones so the pointer never wraps back onto r0.
            if (ptr_q == PTR_LAST) begin
               state_d    = RF_IDLE;
               clr_done_d = 1'b1;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RF_IDLE;
         ptr_q      <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         clr_done_q <= clr_done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else if (!idle) begin
         regs_q[ptr_q] <= '0;
      end else if (wr_ok) begin
         regs_q[wa] <= wd;
      end
   end

   // Set is applied after the write clear so a same-address set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else if (idle) begin
         if (clr_req) begin
            pending_q <= '0;
         end else begin
            if (wr_ok)  pending_q[wa]       <= 1'b0;
            if (set_ok) pending_q[set_addr] <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N_RD; i++) begin : g_rd
      rf_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rdport (
         .regs         (regs_q),
         .pending      (pending_q),
         .ra           (ra[i*ADDR_W +: ADDR_W]),
         .byp_en       (wr_ok),
         .byp_busy_clr (wr_ok && !set_wr_same),
         .wa           (wa),
         .wd           (wd),
         .rd           (rd[i*DATA_W +: DATA_W]),
         .busy         (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, scoreboard queue, soft-clear sequences.
module tb_regfile_mp;

   localparam int unsigned NREG = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ra0, ra1;
   logic [63:0] rd;
   logic [1:0]  rd_busy;
   logic        we, set_en, clr_req;
   logic [4:0]  wa, set_addr;
   logic [31:0] wd;
   logic        clr_busy, clr_done;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra       ({ra1, ra0}),
      .rd       (rd),
      .rd_busy  (rd_busy),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .set_en   (set_en),
      .set_addr (set_addr),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   typedef struct {
      string       name;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  busy;
   } exp_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        set_en;
      logic [4:0]  set_addr;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  busy;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[15];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_total = 0;
   int   busy_total = 0;

   always @(negedge clk) begin
      if (clr_done) done_total++;
      if (clr_busy) busy_total++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string n, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eb);
      exp_t e;
      e.name = n; e.rd0 = e0; e.rd1 = e1; e.busy = eb;
      exp_q.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: empty queue at sample, got rd0=%h", rd[31:0]);
      end else begin
         e = exp_q.pop_front();
         if (rd[31:0] !== e.rd0 || rd[63:32] !== e.rd1 || rd_busy !== e.busy) begin
            n_fail++;
            $display("FAIL %s: got rd0=%h rd1=%h busy=%b, expected rd0=%h rd1=%h busy=%b",
                     e.name, rd[31:0], rd[63:32], rd_busy, e.rd0, e.rd1, e.busy);
         end
      end
   endtask

   task automatic idle_inputs();
      we = 1'b0; wa = '0; wd = '0; set_en = 1'b0; set_addr = '0; clr_req = 1'b0;
   endtask

   task automatic read_all(input string n);
      for (int a = 0; a < NREG; a++) begin
         step();
         ra0 = 5'(a);
         ra1 = 5'(NREG - 1 - a);
         push(n, 32'h0, 32'h0, 2'b00);
         sample();
      end
   endtask

   task automatic fill();
      for (int i = 1; i < NREG; i++) begin
         step();
         we = 1'b1; wa = 5'(i); wd = 32'h100 + i;
      end
      step();
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end, expected finish");
      $fatal(1);
   end

   initial begin
      int busy0, done0;
      logic rd_bad;

      vecs[0]  = '{1'b1, 5'd7 - 5'd2, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
      vecs[2]  = '{1'b1, 5'd0, 32'h1234,   1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,      1'b1, 5'd7, 5'd7, 5'd5, 32'h0, 32'hDEADBEEF, 2'b00};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 32'hDEADBEEF, 2'b01};
      vecs[6]  = '{1'b1, 5'd7, 32'h55,     1'b0, 5'd0, 5'd7, 5'd7, 32'h55, 32'h55, 2'b00};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd7, 5'd0, 32'h55, 32'h0, 2'b00};
      vecs[8]  = '{1'b1, 5'd7, 32'h66,     1'b1, 5'd7, 5'd7, 5'd9, 32'h66, 32'h0, 2'b00};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd7, 5'd9, 32'h66, 32'h0, 2'b01};
      vecs[10] = '{1'b0, 5'd0, 32'h0,      1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h66, 2'b10};
      vecs[11] = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h66, 2'b10};
      vecs[12] = '{1'b1, 5'd9, 32'hA5A5,   1'b0, 5'd0, 5'd9, 5'd7, 32'hA5A5, 32'h66, 2'b10};
      vecs[13] = '{1'b1, 5'd7, 32'h77,     1'b0, 5'd0, 5'd9, 5'd7, 32'hA5A5, 32'h77, 2'b00};
      vecs[14] = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd9, 5'd7, 32'hA5A5, 32'h77, 2'b00};

      idle_inputs();
      ra0 = '0; ra1 = '0;
      #22 rst_n = 1'b1;
      check("reset_clr_busy", {31'h0, clr_busy}, 32'h0);
      check("reset_clr_done", {31'h0, clr_done}, 32'h0);
      read_all("reset_read");

      // Table of single-cycle vectors; state carries from one row to the next.
      for (int v = 0; v < 15; v++) begin
         step();
         we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
         set_en = vecs[v].set_en; set_addr = vecs[v].set_addr;
         ra0 = vecs[v].ra0; ra1 = vecs[v].ra1;
         push($sformatf("vec%0d", v), vecs[v].rd0, vecs[v].rd1, vecs[v].busy);
         sample();
      end
      step();
      idle_inputs();

      // Soft clear with writes and sets attempted throughout.
      fill();
      set_en = 1'b1; set_addr = 5'd3;
      step();
      idle_inputs();
      clr_req = 1'b1;
      step();
      busy0 = busy_total; done0 = done_total; rd_bad = 1'b0;
      clr_req = 1'b0; we = 1'b1; wa = 5'd31; wd = 32'hFFFF_FFFF;
      set_en = 1'b1; set_addr = 5'd4; ra0 = 5'd31; ra1 = 5'd0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (clr_busy && rd[31:0] !== 32'h11F) rd_bad = 1'b1;
         if (clr_done) check("done_with_busy_low", {31'h0, clr_busy}, 32'h0);
         if (!clr_busy) begin
            we = 1'b0; set_en = 1'b0;
         end
      end
      check("clear_busy_cycles", 32'(busy_total - busy0), 32'd31);
      check("clear_done_pulses", 32'(done_total - done0), 32'd1);
      check("clear_read_no_bypass", {31'h0, rd_bad}, 32'h0);
      idle_inputs();
      read_all("after_clear");

      // Reset in the middle of a clear.
      fill();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0; ra0 = 5'd31;
      done0 = done_total;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_clr_busy", {31'h0, clr_busy}, 32'h0);
      check("abort_async_rd", rd[31:0], 32'h0);
      read_all("abort_read");
      check("abort_no_done", 32'(done_total - done0), 32'd0);

      // First write right after reset release.
      @(negedge clk);
      we = 1'b1; wa = 5'd3; wd = 32'h0000BEEF; ra0 = 5'd3; ra1 = 5'd31;
      #1 rst_n = 1'b1;
      step();
      idle_inputs();
      push("first_write", 32'h0000BEEF, 32'h0, 2'b00);
      sample();
      repeat (5) @(negedge clk);
      check("abort_no_late_done", 32'(done_total - done0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
